// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: registers ALU operands, holds them for a settle time, then returns OUT/ZERO over a valid/ready response.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPRN_WIDTH    = 6,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [OPRN_WIDTH-1:0] REQ_OPRN,
  input  logic [DATA_WIDTH-1:0] REQ_OP1,
  input  logic [DATA_WIDTH-1:0] REQ_OP2,
  output logic [DATA_WIDTH-1:0] ALU_OP1,
  output logic [DATA_WIDTH-1:0] ALU_OP2,
  output logic [OPRN_WIDTH-1:0] ALU_OPRN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_ZERO,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  RSP_ZERO,
  output logic                  RSP_ERR,
  output logic                  BUSY,
  output logic [CNT_WIDTH-1:0]  OP_COUNT
);
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
  localparam int SC = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  state_t                r_state, w_next;
  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_op1, r_op2, r_data;
  logic [OPRN_WIDTH-1:0] r_oprn;
  logic                  r_valid, r_zero, r_err;
  logic [CNT_WIDTH-1:0]  r_op_count;
  logic                  w_accept, w_legal;
  assign REQ_READY = (r_state == IDLE) && RST;
  assign w_accept  = REQ_VALID && REQ_READY;
  assign w_legal   = (REQ_OPRN >= OPRN_WIDTH'(1)) && (REQ_OPRN <= OPRN_WIDTH'(9));
  assign ALU_OP1   = r_op1;
  assign ALU_OP2   = r_op2;
  assign ALU_OPRN  = r_oprn;
  assign RSP_VALID = r_valid;
  assign RSP_DATA  = r_data;
  assign RSP_ZERO  = r_zero;
  assign RSP_ERR   = r_err;
  assign BUSY      = r_state != IDLE;
  assign OP_COUNT  = r_op_count;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && w_accept)         ? (w_legal ? DRIVE : RESP) :
             (r_state == DRIVE && r_cnt == 4'd1)   ? RESP :
             (r_state == RESP && RSP_READY)        ? IDLE : r_state;
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_oprn     <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_zero     <= 1'b0;
      r_err      <= 1'b0;
      r_op_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept && w_legal) begin
        r_op1  <= REQ_OP1;
        r_op2  <= REQ_OP2;
        r_oprn <= REQ_OPRN;
        r_cnt  <= 4'(SC);
      end
      if (w_accept && !w_legal) begin
        r_err   <= 1'b1;
        r_data  <= '0;
        r_zero  <= 1'b0;
        r_valid <= 1'b1;
      end
      if (r_state == DRIVE) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          r_data  <= ALU_OUT;
          r_zero  <= ALU_ZERO;
          r_err   <= 1'b0;
          r_valid <= 1'b1;
        end
      end
      // The counter is written only on a completing handshake, so it holds otherwise.
      if (r_state == RESP && RSP_READY) begin
        r_valid <= 1'b0;
        r_oprn  <= '0;
        if (!r_err) r_op_count <= r_op_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of two instances (settle 1 and settle 3) against a behavioural ALU.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_a, rst_b, vld, rdy;
  logic [5:0]  oprn;
  logic [31:0] op1, op2;
  logic        a_req_ready, a_rsp_valid, a_rsp_zero, a_rsp_err, a_busy, a_alu_zero;
  logic [31:0] a_alu_op1, a_alu_op2, a_alu_out, a_rsp_data;
  logic [5:0]  a_alu_oprn;
  logic [15:0] a_op_count;
  logic        b_req_ready, b_rsp_valid, b_rsp_zero, b_rsp_err, b_busy, b_alu_zero;
  logic [31:0] b_alu_op1, b_alu_op2, b_alu_out, b_rsp_data;
  logic [5:0]  b_alu_oprn;
  logic [15:0] b_op_count;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] alu(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      6'h01: return x + y;
      6'h02: return x - y;
      6'h03: return x * y;
      6'h04: return x << y;
      6'h05: return x >> y;
      6'h06: return x & y;
      6'h07: return x | y;
      6'h08: return ~(x | y);
      6'h09: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction
  assign a_alu_out  = alu(a_alu_oprn, a_alu_op1, a_alu_op2);
  assign a_alu_zero = a_alu_out == 32'd0;
  assign b_alu_out  = alu(b_alu_oprn, b_alu_op1, b_alu_op2);
  assign b_alu_zero = b_alu_out == 32'd0;
  alu_issue_ctrl #(.SETTLE_CYCLES(1)) u_a (
    .CLK(clk), .RST(rst_a), .REQ_VALID(vld), .REQ_READY(a_req_ready), .REQ_OPRN(oprn),
    .REQ_OP1(op1), .REQ_OP2(op2), .ALU_OP1(a_alu_op1), .ALU_OP2(a_alu_op2), .ALU_OPRN(a_alu_oprn),
    .ALU_OUT(a_alu_out), .ALU_ZERO(a_alu_zero), .RSP_VALID(a_rsp_valid), .RSP_READY(rdy),
    .RSP_DATA(a_rsp_data), .RSP_ZERO(a_rsp_zero), .RSP_ERR(a_rsp_err), .BUSY(a_busy), .OP_COUNT(a_op_count)
  );
  alu_issue_ctrl #(.SETTLE_CYCLES(3)) u_b (
    .CLK(clk), .RST(rst_b), .REQ_VALID(vld), .REQ_READY(b_req_ready), .REQ_OPRN(oprn),
    .REQ_OP1(op1), .REQ_OP2(op2), .ALU_OP1(b_alu_op1), .ALU_OP2(b_alu_op2), .ALU_OPRN(b_alu_oprn),
    .ALU_OUT(b_alu_out), .ALU_ZERO(b_alu_zero), .RSP_VALID(b_rsp_valid), .RSP_READY(rdy),
    .RSP_DATA(b_rsp_data), .RSP_ZERO(b_rsp_zero), .RSP_ERR(b_rsp_err), .BUSY(b_busy), .OP_COUNT(b_op_count)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_a = 1'b0; rst_b = 1'b0; vld = 1'b1; rdy = 1'b0;
    oprn = 6'h01; op1 = 32'd0; op2 = 32'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_req_ready", a_req_ready, 0);
      chk("rst_rsp_valid", a_rsp_valid, 0);
      chk("rst_alu_oprn", a_alu_oprn, 0);
      chk("rst_op_count", a_op_count, 0);
      chk("rst_busy", a_busy, 0);
    end
    vld = 1'b0;
    rst_a = 1'b1;
    #1 chk("post_rst_ready", a_req_ready, 1);
    step();
    chk("post_rst_ready2", a_req_ready, 1);
    oprn = 6'h01; op1 = 32'd5; op2 = 32'd7; vld = 1'b1; rdy = 1'b1;
    step();
    chk("add_alu_oprn", a_alu_oprn, 6'h01);
    chk("add_alu_op1", a_alu_op1, 5);
    chk("add_busy", a_busy, 1);
    chk("add_valid_early", a_rsp_valid, 0);
    vld = 1'b0;
    step();
    chk("add_valid", a_rsp_valid, 1);
    chk("add_data", a_rsp_data, 12);
    chk("add_zero", a_rsp_zero, 0);
    chk("add_err", a_rsp_err, 0);
    step();
    chk("add_valid_drop", a_rsp_valid, 0);
    chk("add_count", a_op_count, 1);
    chk("add_oprn_clr", a_alu_oprn, 0);
    chk("add_idle", a_busy, 0);
    rdy = 1'b0; oprn = 6'h02; op1 = 32'h10; op2 = 32'h10; vld = 1'b1;
    step();
    oprn = 6'h01; op1 = 32'd3; op2 = 32'd4;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sub_valid_held", a_rsp_valid, 1);
      chk("sub_data", a_rsp_data, 0);
      chk("sub_zero", a_rsp_zero, 1);
      chk("sub_req_ready", a_req_ready, 0);
      chk("sub_alu_oprn", a_alu_oprn, 6'h02);
    end
    rdy = 1'b1;
    step();
    chk("sub_handshake", a_rsp_valid, 0);
    chk("sub_count", a_op_count, 2);
    chk("sub_ready_again", a_req_ready, 1);
    step();
    vld = 1'b0;
    chk("second_oprn", a_alu_oprn, 6'h01);
    chk("second_op1", a_alu_op1, 3);
    step();
    chk("second_data", a_rsp_data, 7);
    step();
    chk("second_count", a_op_count, 3);
    oprn = 6'h0A; vld = 1'b1;
    step();
    vld = 1'b0;
    chk("ill_alu_oprn", a_alu_oprn, 0);
    chk("ill_valid", a_rsp_valid, 1);
    chk("ill_err", a_rsp_err, 1);
    chk("ill_data", a_rsp_data, 0);
    step();
    chk("ill_valid_drop", a_rsp_valid, 0);
    chk("ill_count", a_op_count, 3);
    chk("ill_err_retained", a_rsp_err, 1);
    oprn = 6'h06; op1 = 32'hF0; op2 = 32'h3C; vld = 1'b1;
    step();
    vld = 1'b0;
    step();
    chk("and_data", a_rsp_data, 32'h30);
    chk("and_err", a_rsp_err, 0);
    step();
    chk("and_count", a_op_count, 4);
    force u_a.r_op_count = 16'hFFFF;
    #1 release u_a.r_op_count;
    chk("preload_count", a_op_count, 16'hFFFF);
    oprn = 6'h01; op1 = 32'd1; op2 = 32'd1; vld = 1'b1;
    step();
    vld = 1'b0;
    step();
    chk("wrap_data", a_rsp_data, 2);
    step();
    chk("wrap_count", a_op_count, 16'h0000);
    rst_a = 1'b0; rst_b = 1'b1;
    step();
    chk("b_ready", b_req_ready, 1);
    oprn = 6'h03; op1 = 32'd6; op2 = 32'd7; vld = 1'b1; rdy = 1'b1;
    step();
    vld = 1'b0;
    chk("mul_oprn", b_alu_oprn, 6'h03);
    chk("mul_op1", b_alu_op1, 6);
    chk("mul_valid0", b_rsp_valid, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mul_hold_valid", b_rsp_valid, 0);
      chk("mul_hold_oprn", b_alu_oprn, 6'h03);
      chk("mul_hold_op2", b_alu_op2, 7);
    end
    step();
    chk("mul_valid", b_rsp_valid, 1);
    chk("mul_data", b_rsp_data, 42);
    step();
    chk("mul_count", b_op_count, 1);
    oprn = 6'h01; op1 = 32'd9; op2 = 32'd1; vld = 1'b1;
    step();
    vld = 1'b0;
    chk("abort_busy", b_busy, 1);
    step();
    rst_b = 1'b0;
    step();
    chk("abort_ready", b_req_ready, 0);
    chk("abort_op1", b_alu_op1, 0);
    chk("abort_op2", b_alu_op2, 0);
    chk("abort_oprn", b_alu_oprn, 0);
    chk("abort_valid", b_rsp_valid, 0);
    chk("abort_data", b_rsp_data, 0);
    chk("abort_zero", b_rsp_zero, 0);
    chk("abort_err", b_rsp_err, 0);
    chk("abort_busy0", b_busy, 0);
    chk("abort_count", b_op_count, 0);
    rst_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_rsp", b_rsp_valid, 0);
      chk("abort_idle", b_busy, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
